// File: rtl/knn_sched_pkg.sv
// Shared definitions for the k-NN run scheduler: state encoding and default
// widths/latencies.
package knn_sched_pkg;

  localparam int KNN_CNT_W    = 16;
  localparam int KNN_SORT_LAT = 2;
  localparam int KNN_TO_CYC   = 1024;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_CLEAR  = 3'd1,
    ST_LOAD   = 3'd2,
    ST_SETTLE = 3'd3,
    ST_DONE   = 3'd4
  } state_e;

  function automatic logic is_busy(input state_e s);
    return (s == ST_CLEAR) || (s == ST_LOAD) || (s == ST_SETTLE);
  endfunction

endpackage

// File: rtl/knn_sched_cnt.sv
// Up-counter with synchronous clear, parallel load and a terminal-value compare.
// Clear wins over load, load wins over increment.
module knn_sched_cnt
  import knn_sched_pkg::*;
#(
  parameter int W = KNN_CNT_W
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         inc,
  input  logic [W-1:0] term_val,
  output logic [W-1:0] q,
  output logic         at_term
);

  logic [W-1:0] q_reg;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q_reg <= '0;
    end else if (clr) begin
      q_reg <= '0;
    end else if (load) begin
      q_reg <= load_val;
    end else if (inc) begin
      q_reg <= q_reg + W'(1);
    end
  end

  assign q       = q_reg;
  assign at_term = (q_reg == term_val);

endmodule

// File: rtl/knn_sched.sv
// Run scheduler for the knn_core array: clear, stream n_train points, settle, done.
// Define KNN_SCHED_TIMEOUT_EN to build in the LOAD-phase watchdog.
module knn_sched
  import knn_sched_pkg::*;
#(
  parameter int CNT_W    = KNN_CNT_W,
  parameter int SORT_LAT = KNN_SORT_LAT,
  parameter int TO_CYC   = KNN_TO_CYC
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             abort,
  input  logic [CNT_W-1:0] n_train,
  input  logic             train_valid,
  output logic             train_ready,
  output logic             core_clr,
  output logic             core_en,
  output logic             core_load,
  output logic [CNT_W-1:0] loaded,
  output logic             busy,
  output logic             done,
  output logic             timeout
);

  localparam int AUX_MAX = (TO_CYC > SORT_LAT) ? TO_CYC : SORT_LAT;
  localparam int AUX_W   = $clog2(AUX_MAX + 1);
  localparam logic [AUX_W-1:0] SETTLE_TERM = AUX_W'(SORT_LAT - 1);
  localparam logic [AUX_W-1:0] TO_TERM     = AUX_W'(TO_CYC - 1);

  state_e           state_reg, state_next;
  logic [CNT_W-1:0] n_reg;
  logic             clr_reg, en_reg, ready_reg, busy_reg, done_reg;

  logic             start_go, xfer, wd_fire;
  logic             loaded_last;
  logic             aux_clr, aux_inc, aux_term;
  logic [AUX_W-1:0] aux_term_val, aux_q_unused;

  assign start_go = start && ((state_reg == ST_IDLE) || (state_reg == ST_DONE));
  // Abort masks the handshake so a same-cycle point is never loaded.
  assign train_ready = ready_reg & ~abort;
  assign core_load   = train_valid & train_ready;
  assign xfer        = core_load;

  knn_sched_cnt #(.W(CNT_W)) u_loaded_cnt (
    .clk      (clk),
    .rst      (rst),
    .clr      (start_go),
    .load     (1'b0),
    .load_val ('0),
    .inc      (xfer),
    .term_val (n_reg - CNT_W'(1)),
    .q        (loaded),
    .at_term  (loaded_last)
  );

  // One counter times both the SETTLE delay and the LOAD idle watchdog; it is
  // cleared on entry to LOAD, on every transfer, and outside LOAD/SETTLE.
  assign aux_clr      = !((state_reg == ST_LOAD) || (state_reg == ST_SETTLE)) || xfer;
  assign aux_term_val = (state_reg == ST_SETTLE) ? SETTLE_TERM : TO_TERM;

`ifdef KNN_SCHED_TIMEOUT_EN
  assign aux_inc = (state_reg == ST_SETTLE) || ((state_reg == ST_LOAD) && !xfer);
  assign wd_fire = (state_reg == ST_LOAD) && !xfer && !abort && aux_term;
`else
  assign aux_inc = (state_reg == ST_SETTLE);
  assign wd_fire = 1'b0;
`endif

  knn_sched_cnt #(.W(AUX_W)) u_aux_cnt (
    .clk      (clk),
    .rst      (rst),
    .clr      (aux_clr),
    .load     (1'b0),
    .load_val ('0),
    .inc      (aux_inc),
    .term_val (aux_term_val),
    .q        (aux_q_unused),
    .at_term  (aux_term)
  );

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_IDLE, ST_DONE: if (start) state_next = ST_CLEAR;
      ST_CLEAR:         state_next = (n_reg == '0) ? ST_DONE : ST_LOAD;
      ST_LOAD: begin
        if (xfer && loaded_last) state_next = ST_SETTLE;
        else if (wd_fire)        state_next = ST_DONE;
      end
      ST_SETTLE:        if (aux_term) state_next = ST_DONE;
      default:          state_next = ST_IDLE;
    endcase
    if (abort && is_busy(state_reg)) state_next = ST_IDLE;
  end

  // Output flags are registered from the next state so they line up with it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= ST_IDLE;
      n_reg     <= '0;
      clr_reg   <= 1'b0;
      en_reg    <= 1'b0;
      ready_reg <= 1'b0;
      busy_reg  <= 1'b0;
      done_reg  <= 1'b0;
    end else begin
      state_reg <= state_next;
      if (start_go) n_reg <= n_train;
      clr_reg   <= (state_next == ST_CLEAR);
      en_reg    <= (state_next == ST_LOAD) || (state_next == ST_SETTLE);
      ready_reg <= (state_next == ST_LOAD);
      busy_reg  <= is_busy(state_next);
      done_reg  <= (state_next == ST_DONE);
    end
  end

`ifdef KNN_SCHED_TIMEOUT_EN
  logic timeout_reg;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      timeout_reg <= 1'b0;
    end else if (start_go) begin
      timeout_reg <= 1'b0;
    end else if (wd_fire) begin
      timeout_reg <= 1'b1;
    end
  end

  assign timeout = timeout_reg;
`else
  assign timeout = 1'b0;
`endif

  assign core_clr = clr_reg;
  assign core_en  = en_reg;
  assign busy     = busy_reg;
  assign done     = done_reg;

endmodule

// File: tb/tb_knn_sched.sv
// Self-checking bench for knn_sched; the reference is a run-level model that
// predicts handshake, load count and done timing from n_train and stimulus.
module tb_knn_sched;

  localparam int CNT_W    = 16;
  localparam int SORT_LAT = 2;
  localparam int TO_CYC   = 8;

  logic             clk = 1'b0;
  logic             rst;
  logic             start;
  logic             abort;
  logic [CNT_W-1:0] n_train;
  logic             train_valid;
  logic             train_ready;
  logic             core_clr;
  logic             core_en;
  logic             core_load;
  logic [CNT_W-1:0] loaded;
  logic             busy;
  logic             done;
  logic             timeout;

  knn_sched #(.CNT_W(CNT_W), .SORT_LAT(SORT_LAT), .TO_CYC(TO_CYC)) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .abort       (abort),
    .n_train     (n_train),
    .train_valid (train_valid),
    .train_ready (train_ready),
    .core_clr    (core_clr),
    .core_en     (core_en),
    .core_load   (core_load),
    .loaded      (loaded),
    .busy        (busy),
    .done        (done),
    .timeout     (timeout)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Per-run observations collected by run(), judged by each test task.
  int r_loads, r_first, r_last, r_done_at, r_loaded_done, r_timeout, r_clr;
  int r_hs_bad, r_ready_bad, r_loaded_bad, r_en_bad, r_busy_bad, r_clr_bad;
  int r_abort_load, r_pa_busy, r_pa_done, r_pa_ready, r_pa_en;

  // Starts a run (entered at posedge+1) and steps it until done, an abort, or
  // the cycle budget. mode: 0 valid high, 1 valid on odd cycles, 2 random,
  // 3 valid only until stall_after loads. Cycle 0 is the CLEAR cycle.
  task automatic run(input int n, input int mode, input int stall_after,
                     input int abort_after, input bit abort_at_start,
                     input bit noise, input int budget);
    int  cnt;
    int  idle_streak;
    bit  ab_now;
    cnt = 0; idle_streak = 0;
    r_loads = 0; r_first = -1; r_last = -1; r_done_at = -1; r_loaded_done = -1;
    r_timeout = -1; r_clr = 0; r_hs_bad = 0; r_ready_bad = 0; r_loaded_bad = 0;
    r_en_bad = 0; r_busy_bad = 0; r_clr_bad = 0; r_abort_load = -1;
    r_pa_busy = -1; r_pa_done = -1; r_pa_ready = -1; r_pa_en = -1;
    start = 1'b1; abort = abort_at_start; n_train = CNT_W'(n); train_valid = 1'b0;
    @(posedge clk); #1;
    start = 1'b0; abort = 1'b0;
    for (int c = 0; c < budget; c++) begin
      case (mode)
        0: train_valid = 1'b1;
        1: train_valid = (c % 2 == 1);
        2: train_valid = (idle_streak >= 3) || ($urandom_range(0, 3) != 0);
        default: train_valid = (cnt < stall_after);
      endcase
      idle_streak = train_valid ? 0 : idle_streak + 1;
      ab_now = (abort_after >= 0) && (c >= 1) && (cnt == abort_after);
      abort  = ab_now;
      start  = noise && (c >= 1) && (cnt < n) && ($urandom_range(0, 2) == 0);
      @(negedge clk);
      if (ab_now) begin
        r_abort_load = int'(core_load);
        @(posedge clk); #1;
        abort = 1'b0; start = 1'b0;
        @(negedge clk);
        r_pa_busy = int'(busy); r_pa_done = int'(done);
        r_pa_ready = int'(train_ready); r_pa_en = int'(core_en);
        @(posedge clk); #1;
        break;
      end
      if (core_clr !== (c == 0)) r_clr_bad++;
      if (core_clr === 1'b1) r_clr++;
      if (core_load !== (train_valid && train_ready)) r_hs_bad++;
      if (loaded !== CNT_W'(cnt)) r_loaded_bad++;
      if (busy !== !done) r_busy_bad++;
      if (!done && core_en !== (c >= 1)) r_en_bad++;
      if (!done && train_ready !== ((c >= 1) && (cnt < n))) r_ready_bad++;
      if (core_load === 1'b1) begin
        if (r_first < 0) r_first = c;
        r_last = c;
        cnt++;
      end
      if (done === 1'b1) begin
        r_done_at = c; r_loaded_done = int'(loaded); r_timeout = int'(timeout);
      end
      @(posedge clk); #1;
      if (r_done_at >= 0) break;
    end
    r_loads = cnt;
    start = 1'b0; abort = 1'b0; train_valid = 1'b0;
    $display("run n=%0d mode=%0d loads=%0d first=%0d last=%0d done_at=%0d loaded=%0d",
             n, mode, r_loads, r_first, r_last, r_done_at, r_loaded_done);
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; abort = 1'b0; train_valid = 1'b0; n_train = '0;
    @(negedge clk);
    checks++;
    if ({train_ready, core_clr, core_en, core_load, busy, done, timeout} !== 7'b0) begin
      errors++;
      $display("FAIL reset_flags: got %b expected 0000000",
               {train_ready, core_clr, core_en, core_load, busy, done, timeout});
    end
    checks++;
    if (loaded !== '0) begin
      errors++; $display("FAIL reset_loaded: got %0d expected 0", loaded);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      errors++; $display("FAIL reset_idle: busy=%b done=%b expected 0 0", busy, done);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_basic();
    run(4, 0, 0, -1, 1'b0, 1'b0, 40);
    checks++;
    if (r_clr !== 1 || r_clr_bad !== 0) begin
      errors++; $display("FAIL basic_clr: cycles=%0d bad=%0d expected 1 0", r_clr, r_clr_bad);
    end
    checks++;
    if (r_loads !== 4 || r_first !== 1 || r_last !== 4) begin
      errors++;
      $display("FAIL basic_loads: got %0d at %0d..%0d expected 4 at 1..4", r_loads, r_first, r_last);
    end
    checks++;
    if (r_done_at !== r_last + SORT_LAT + 1) begin
      errors++; $display("FAIL basic_done_lat: got %0d expected %0d", r_done_at, r_last + SORT_LAT + 1);
    end
    checks++;
    if (r_loaded_done !== 4) begin
      errors++; $display("FAIL basic_loaded: got %0d expected 4", r_loaded_done);
    end
    checks++;
    if (r_hs_bad + r_ready_bad + r_loaded_bad + r_en_bad + r_busy_bad !== 0) begin
      errors++;
      $display("FAIL basic_cycle: hs=%0d ready=%0d loaded=%0d en=%0d busy=%0d expected all 0",
               r_hs_bad, r_ready_bad, r_loaded_bad, r_en_bad, r_busy_bad);
    end
  endtask

  task automatic test_toggle();
    run(3, 1, 0, -1, 1'b0, 1'b0, 40);
    checks++;
    if (r_loads !== 3 || r_first !== 1 || r_last !== 5) begin
      errors++;
      $display("FAIL toggle_loads: got %0d at %0d..%0d expected 3 at 1..5", r_loads, r_first, r_last);
    end
    checks++;
    if (r_hs_bad !== 0 || r_ready_bad !== 0) begin
      errors++; $display("FAIL toggle_handshake: hs=%0d ready=%0d expected 0 0", r_hs_bad, r_ready_bad);
    end
    checks++;
    if (r_loaded_done !== 3 || r_done_at !== r_last + SORT_LAT + 1) begin
      errors++;
      $display("FAIL toggle_done: loaded=%0d at %0d expected 3 at %0d",
               r_loaded_done, r_done_at, r_last + SORT_LAT + 1);
    end
  endtask

  task automatic test_zero();
    run(0, 0, 0, -1, 1'b0, 1'b0, 20);
    checks++;
    if (r_clr !== 1 || r_done_at !== 1) begin
      errors++; $display("FAIL zero_seq: clr=%0d done_at=%0d expected 1 1", r_clr, r_done_at);
    end
    checks++;
    if (r_loads !== 0 || r_loaded_done !== 0) begin
      errors++; $display("FAIL zero_loads: loads=%0d loaded=%0d expected 0 0", r_loads, r_loaded_done);
    end
  endtask

  task automatic test_abort();
    run(5, 0, 0, 2, 1'b0, 1'b0, 40);
    checks++;
    if (r_loads !== 2 || r_abort_load !== 0) begin
      errors++;
      $display("FAIL abort_load: loads=%0d load_on_abort=%0d expected 2 0", r_loads, r_abort_load);
    end
    checks++;
    if (r_pa_busy !== 0 || r_pa_done !== 0 || r_pa_ready !== 0 || r_pa_en !== 0) begin
      errors++;
      $display("FAIL abort_idle: busy=%0d done=%0d ready=%0d en=%0d expected 0 0 0 0",
               r_pa_busy, r_pa_done, r_pa_ready, r_pa_en);
    end
    run(5, 0, 0, -1, 1'b0, 1'b0, 40);
    checks++;
    if (r_loads !== 5 || r_loaded_done !== 5 || r_done_at !== r_last + SORT_LAT + 1) begin
      errors++;
      $display("FAIL abort_rerun: loads=%0d loaded=%0d done_at=%0d expected 5 5 %0d",
               r_loads, r_loaded_done, r_done_at, r_last + SORT_LAT + 1);
    end
    run(3, 0, 0, -1, 1'b1, 1'b0, 40);
    checks++;
    if (r_loads !== 3 || r_loaded_done !== 3 || r_clr !== 1) begin
      errors++;
      $display("FAIL abort_with_start: loads=%0d loaded=%0d clr=%0d expected 3 3 1",
               r_loads, r_loaded_done, r_clr);
    end
  endtask

  task automatic test_reset_mid();
    start = 1'b1; n_train = CNT_W'(6); train_valid = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (3) begin @(posedge clk); #1; end
    checks++;
    if (busy !== 1'b1 || loaded !== CNT_W'(2)) begin
      errors++; $display("FAIL rstmid_pre: busy=%b loaded=%0d expected 1 2", busy, loaded);
    end
    #2 rst = 1'b1;
    #1;
    checks++;
    if ({train_ready, core_clr, core_en, core_load, busy, done, timeout} !== 7'b0 || loaded !== '0) begin
      errors++;
      $display("FAIL rstmid_async: flags=%b loaded=%0d expected 0000000 0",
               {train_ready, core_clr, core_en, core_load, busy, done, timeout}, loaded);
    end
    @(posedge clk); #1;
    rst = 1'b0; train_valid = 1'b0;
    @(negedge clk);
    checks++;
    if (busy !== 1'b0 || done !== 1'b0 || train_ready !== 1'b0) begin
      errors++;
      $display("FAIL rstmid_idle: busy=%b done=%b ready=%b expected 0 0 0", busy, done, train_ready);
    end
    @(posedge clk); #1;
    run(2, 0, 0, -1, 1'b0, 1'b0, 40);
    checks++;
    if (r_loads !== 2 || r_loaded_done !== 2 || r_clr !== 1) begin
      errors++;
      $display("FAIL rstmid_rerun: loads=%0d loaded=%0d clr=%0d expected 2 2 1", r_loads, r_loaded_done, r_clr);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 6; i++) begin
      int n;
      n = $urandom_range(1, 10);
      run(n, 2, 0, -1, 1'b0, 1'b1, 200);
      checks++;
      if (r_loads !== n || r_loaded_done !== n) begin
        errors++; $display("FAIL random_count: run %0d loads=%0d loaded=%0d expected %0d",
                           i, r_loads, r_loaded_done, n);
      end
      checks++;
      if (r_done_at !== r_last + SORT_LAT + 1) begin
        errors++; $display("FAIL random_done_lat: run %0d got %0d expected %0d",
                           i, r_done_at, r_last + SORT_LAT + 1);
      end
      checks++;
      if (r_hs_bad + r_ready_bad + r_loaded_bad + r_en_bad + r_busy_bad + r_clr_bad !== 0) begin
        errors++;
        $display("FAIL random_cycle: run %0d hs=%0d ready=%0d loaded=%0d en=%0d busy=%0d clr=%0d expected all 0",
                 i, r_hs_bad, r_ready_bad, r_loaded_bad, r_en_bad, r_busy_bad, r_clr_bad);
      end
    end
  endtask

  task automatic test_timeout();
`ifdef KNN_SCHED_TIMEOUT_EN
    run(3, 3, 1, -1, 1'b0, 1'b0, 60);
    checks++;
    if (r_done_at !== r_last + TO_CYC + 1 || r_timeout !== 1) begin
      errors++;
      $display("FAIL timeout_fire: done_at=%0d timeout=%0d expected %0d 1",
               r_done_at, r_timeout, r_last + TO_CYC + 1);
    end
    checks++;
    if (r_loads !== 1 || r_loaded_done !== 1) begin
      errors++; $display("FAIL timeout_loaded: loads=%0d loaded=%0d expected 1 1", r_loads, r_loaded_done);
    end
    run(2, 0, 0, -1, 1'b0, 1'b0, 40);
    checks++;
    if (r_timeout !== 0 || r_loaded_done !== 2) begin
      errors++; $display("FAIL timeout_clear: timeout=%0d loaded=%0d expected 0 2", r_timeout, r_loaded_done);
    end
`else
    run(3, 3, 1, -1, 1'b0, 1'b0, 30);
    checks++;
    if (r_done_at !== -1 || r_loads !== 1) begin
      errors++; $display("FAIL nowd_wait: done_at=%0d loads=%0d expected -1 1", r_done_at, r_loads);
    end
    @(negedge clk);
    checks++;
    if (timeout !== 1'b0 || busy !== 1'b1 || loaded !== CNT_W'(1)) begin
      errors++;
      $display("FAIL nowd_state: timeout=%b busy=%b loaded=%0d expected 0 1 1", timeout, busy, loaded);
    end
    @(posedge clk); #1;
    abort = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0;
    @(negedge clk);
    checks++;
    if (busy !== 1'b0) begin
      errors++; $display("FAIL nowd_abort: busy=%b expected 0", busy);
    end
    @(posedge clk); #1;
`endif
  endtask

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not finish, expected completion");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_basic();
    test_toggle();
    test_zero();
    test_abort();
    test_reset_mid();
    test_random();
    test_timeout();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
